dequant_skew_feeder: RTL and testbench

Streams quantized partial-sum rows back into the systolic array: each lane is sign-extended from the quantized width to the array accumulator width, optionally re-aligned by a fixed left shift, and skewed diagonally so that lane i enters the array i cycles after lane 0. It is the reverse path of the output quantizer. It sits between the SRAM read port and the array's partial-sum preload inputs, and preloads the accumulators (bias or previous partial sums) for the next tile.

---
 rtl/dequant_skew_feeder_pkg.sv | 20 ++
 rtl/dequant_skew_feeder_if.sv | 32 +++
 rtl/dequant_skew_feeder_skew_delay_line.sv | 33 +++
 rtl/dequant_skew_feeder.sv | 96 +++++++++
 tb/tb_dequant_skew_feeder.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dequant_skew_feeder_pkg.sv
// Shared types and width helpers for the dequantizing skew feeder.
// Imported by the interface, the delay line and the top level.
package dequant_skew_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // Accumulator lane width of the systolic array.
  function automatic int calc_ori_width(input int data_width, input int weight_width);
    return data_width + weight_width + 5;
  endfunction

  function automatic int calc_cnt_width(input int array_size);
    return $clog2(array_size + 1);
  endfunction

endpackage

// File: rtl/dequant_skew_feeder_if.sv
// Row-in / skewed-lanes-out bus of the dequantizing skew feeder.
// The feeder uses the slave modport; the row source uses master.
interface dequant_skew_feeder_if
  import dequant_skew_feeder_pkg::*;
#(
  parameter int ARRAY_SIZE        = 16,
  parameter int DATA_WIDTH        = 8,
  parameter int WEIGHT_WIDTH      = 16,
  parameter int OUTPUT_DATA_WIDTH = 24
);
  localparam int ORI_WIDTH = calc_ori_width(DATA_WIDTH, WEIGHT_WIDTH);

  logic                                  in_valid;
  logic                                  in_ready;
  logic                                  in_last;
  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] in_data;
  logic [ARRAY_SIZE-1:0]                 out_valid;
  logic [ARRAY_SIZE*ORI_WIDTH-1:0]       out_data;
  logic                                  busy;
  logic                                  done;

  modport master (
    output in_valid, in_last, in_data,
    input  in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  in_valid, in_last, in_data,
    output in_ready, out_valid, out_data, busy, done
  );

endinterface

// File: rtl/dequant_skew_feeder_skew_delay_line.sv
// Fixed-depth register chain carrying {valid, data} for one lane.
// DEPTH=0 degenerates to a wire.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             srstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ srstn;
    assign q = d;
  end else begin : g_chain
    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: every stage is cleared, not just the head; a reset must kill rows already in flight.
    always_ff @(posedge clk) begin
      if (!srstn) begin
        for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
      end else begin
        stage[0] <= d;
        for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/dequant_skew_feeder.sv
// Sign-extends quantized rows to accumulator width and feeds them into the
// array as a diagonal: lane i leaves i cycles after lane 0.
module dequant_skew_feeder
  import dequant_skew_feeder_pkg::*;
#(
  parameter int ARRAY_SIZE        = 16,
  parameter int DATA_WIDTH        = 8,
  parameter int WEIGHT_WIDTH      = 16,
  parameter int OUTPUT_DATA_WIDTH = 24,
  parameter int FRAC_SHIFT        = 0
) (
  input logic                 clk,
  input logic                 srstn,
  dequant_skew_feeder_if.slave bus
);

  localparam int ORI_WIDTH = calc_ori_width(DATA_WIDTH, WEIGHT_WIDTH);
  localparam int CNT_WIDTH = calc_cnt_width(ARRAY_SIZE);

  state_e                 state, state_next;
  logic [CNT_WIDTH-1:0]   flush_cnt;
  logic                   accept;
  logic                   deq_valid;
  logic [ORI_WIDTH-1:0]   deq_data [ARRAY_SIZE];

  function automatic logic [ORI_WIDTH-1:0] dequant(input logic [OUTPUT_DATA_WIDTH-1:0] q);
    logic [ORI_WIDTH-1:0] ext;
    ext = {{(ORI_WIDTH-OUTPUT_DATA_WIDTH){q[OUTPUT_DATA_WIDTH-1]}}, q};
    return ext << FRAC_SHIFT;
  endfunction

  // Ready depends on state alone, so accept is derived here rather than from bus.in_ready.
  assign accept = bus.in_valid && (state != FLUSH);

  // NOTE: state registers use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= (state == FLUSH) ? flush_cnt + CNT_WIDTH'(1) : '0;
    end
  end

  // NOTE: every output is defaulted first so no path through the case can infer a latch.
  always_comb begin
    state_next   = state;
    bus.in_ready = 1'b1;
    bus.busy     = (state != IDLE);
    bus.done     = 1'b0;
    case (state)
      IDLE, STREAM: begin
        if (accept) state_next = bus.in_last ? FLUSH : STREAM;
      end
      FLUSH: begin
        bus.in_ready = 1'b0;
        if (flush_cnt == CNT_WIDTH'(ARRAY_SIZE - 1)) begin
          bus.done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Invalid slots carry zero data so idle lanes present 0 to the array.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      deq_valid <= 1'b0;
      for (int i = 0; i < ARRAY_SIZE; i++) deq_data[i] <= '0;
    end else begin
      deq_valid <= accept;
      for (int i = 0; i < ARRAY_SIZE; i++)
        deq_data[i] <= accept ? dequant(bus.in_data[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]) : '0;
    end
  end

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [ORI_WIDTH:0] lane_q;

    skew_delay_line #(
      .DEPTH(i),
      .WIDTH(ORI_WIDTH + 1)
    ) u_skew (
      .clk  (clk),
      .srstn(srstn),
      .d    ({deq_valid, deq_data[i]}),
      .q    (lane_q)
    );

    assign bus.out_valid[i]                    = lane_q[ORI_WIDTH];
    assign bus.out_data[i*ORI_WIDTH +: ORI_WIDTH] = lane_q[ORI_WIDTH-1:0];
  end

endmodule

// File: tb/tb_dequant_skew_feeder.sv
// Directed bench for dequant_skew_feeder: two instances (shift 0 and 4) share
// the same stimulus; a per-edge history predicts every lane at every cycle.
module tb_dequant_skew_feeder;

  localparam int N    = 16;
  localparam int QW   = 24;
  localparam int OW   = 29;
  localparam int MAXE = 2048;

  logic clk;
  logic srstn;
  logic drv_valid;
  logic drv_last;
  logic [QW-1:0] drv_data [N];

  int total = 0;
  int bad   = 0;

  int   e = 0;
  int   flush_left = 0;
  logic mbusy = 1'b0;
  logic hv [MAXE];
  logic [QW-1:0] hd [MAXE][N];
  int   v15_cnt = 0;

  dequant_skew_feeder_if #(.ARRAY_SIZE(N), .DATA_WIDTH(8), .WEIGHT_WIDTH(16),
                           .OUTPUT_DATA_WIDTH(QW)) bus0 ();
  dequant_skew_feeder_if #(.ARRAY_SIZE(N), .DATA_WIDTH(8), .WEIGHT_WIDTH(16),
                           .OUTPUT_DATA_WIDTH(QW)) bus4 ();

  dequant_skew_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(8), .WEIGHT_WIDTH(16),
                        .OUTPUT_DATA_WIDTH(QW), .FRAC_SHIFT(0))
    dut0 (.clk(clk), .srstn(srstn), .bus(bus0.slave));

  dequant_skew_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(8), .WEIGHT_WIDTH(16),
                        .OUTPUT_DATA_WIDTH(QW), .FRAC_SHIFT(4))
    dut4 (.clk(clk), .srstn(srstn), .bus(bus4.slave));

  assign bus0.in_valid = drv_valid;
  assign bus0.in_last  = drv_last;
  assign bus4.in_valid = drv_valid;
  assign bus4.in_last  = drv_last;
  for (genvar i = 0; i < N; i++) begin : g_drv
    assign bus0.in_data[i*QW +: QW] = drv_data[i];
    assign bus4.in_data[i*QW +: QW] = drv_data[i];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [OW-1:0] model_deq(input logic [QW-1:0] x, input int s);
    logic [OW-1:0] t;
    t = {{(OW-QW){x[QW-1]}}, x};
    return t << s;
  endfunction

  function automatic logic [QW-1:0] rowpat(input int r, input int i);
    return 24'hA00000 | QW'(r << 8) | QW'(i);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_row(input logic [QW-1:0] v);
    for (int i = 0; i < N; i++) drv_data[i] = v;
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      int            idx;
      logic          v;
      logic [OW-1:0] x0, x4;
      idx = e - i;
      v   = (idx >= 0) && hv[idx];
      x0  = v ? model_deq(hd[idx][i], 0) : '0;
      x4  = v ? model_deq(hd[idx][i], 4) : '0;
      check($sformatf("e%0d_lane%0d_v0", e, i), 64'(bus0.out_valid[i]), 64'(v));
      check($sformatf("e%0d_lane%0d_v4", e, i), 64'(bus4.out_valid[i]), 64'(v));
      check($sformatf("e%0d_lane%0d_d0", e, i), 64'(bus0.out_data[i*OW +: OW]), 64'(x0));
      check($sformatf("e%0d_lane%0d_d4", e, i), 64'(bus4.out_data[i*OW +: OW]), 64'(x4));
    end
    check($sformatf("e%0d_ready", e), 64'(bus0.in_ready), 64'(flush_left == 0));
    check($sformatf("e%0d_busy", e),  64'(bus0.busy),     64'(mbusy));
    check($sformatf("e%0d_done", e),  64'(bus0.done),     64'(flush_left == 1));
    check($sformatf("e%0d_done4", e), 64'(bus4.done),     64'(flush_left == 1));
    if (bus0.out_valid[15] === 1'b1) v15_cnt++;
  endtask

  // One clock: predict the handshake, advance the model at the edge, compare #1 later.
  task automatic cycle();
    logic acc;
    acc = srstn && drv_valid && (flush_left == 0);
    @(posedge clk);
    e++;
    if (!srstn) begin
      for (int k = 0; k <= e; k++) hv[k] = 1'b0;
      flush_left = 0;
      mbusy      = 1'b0;
    end else begin
      hv[e] = acc;
      for (int i = 0; i < N; i++) hd[e][i] = acc ? drv_data[i] : '0;
      if (flush_left > 0) begin
        flush_left--;
        if (flush_left == 0) mbusy = 1'b0;
      end else if (acc) begin
        mbusy = 1'b1;
        if (drv_last) flush_left = N;
      end
    end
    #1;
    compare_all();
  endtask

  initial begin
    int low;
    int r;
    for (int k = 0; k < MAXE; k++) hv[k] = 1'b0;
    srstn     = 1'b0;
    drv_valid = 1'b1;
    drv_last  = 1'b1;
    set_row(24'h123456);

    // Reset with inputs active: they must be ignored.
    repeat (3) cycle();
    check("rst_ready", 64'(bus0.in_ready), 64'(1));
    check("rst_out_valid", 64'(bus0.out_valid), 64'(0));
    srstn     = 1'b1;
    drv_valid = 1'b0;
    cycle();

    // Single-row tile of +32767.
    set_row(24'h00_7FFF);
    drv_valid = 1'b1;
    drv_last  = 1'b1;
    cycle();
    low = (bus0.in_ready === 1'b0) ? 1 : 0;
    check("t1_lane0", 64'(bus0.out_data[0 +: OW]), 64'(29'h0000_7FFF));
    drv_valid = 1'b0;
    for (int k = 2; k <= 20; k++) begin
      cycle();
      if (bus0.in_ready === 1'b0) low++;
      if (k <= 16) begin
        check($sformatf("t1_lane%0d_v", k-1), 64'(bus0.out_valid[k-1]), 64'(1));
        check($sformatf("t1_lane%0d", k-1), 64'(bus0.out_data[(k-1)*OW +: OW]), 64'(29'h0000_7FFF));
      end
      if (k == 16) check("t1_done", 64'(bus0.done), 64'(1));
    end
    check("t1_ready_low_cycles", 64'(low), 64'(16));

    // Negative value, checked with both shift settings.
    set_row(24'hFF_8000);
    drv_valid = 1'b1;
    cycle();
    check("t2_lane0_s0", 64'(bus0.out_data[0 +: OW]), 64'(29'h1FFF_8000));
    check("t2_lane0_s4", 64'(bus4.out_data[0 +: OW]), 64'(29'h1FF8_0000));
    drv_valid = 1'b0;
    for (int k = 2; k <= 17; k++) begin
      cycle();
      if (k == 16) check("t2_lane15_s4", 64'(bus4.out_data[15*OW +: OW]), 64'(29'h1FF8_0000));
    end

    // 8-row tile with a 2-cycle bubble before row 3.
    v15_cnt = 0;
    for (int rr = 0; rr < 8; rr++) begin
      if (rr == 3) begin
        drv_valid = 1'b0;
        cycle();
        cycle();
      end
      for (int i = 0; i < N; i++) drv_data[i] = rowpat(rr, i);
      drv_valid = 1'b1;
      drv_last  = (rr == 7);
      cycle();
    end
    drv_valid = 1'b0;
    for (int k = 2; k <= 17; k++) begin
      cycle();
      if (k == 16) check("t3_done", 64'(bus0.done), 64'(1));
    end
    check("t3_lane15_rows", 64'(v15_cnt), 64'(8));

    // Back-to-back tiles with in_valid held high.
    for (int rr = 0; rr < 3; rr++) begin
      for (int i = 0; i < N; i++) drv_data[i] = rowpat(rr + 16, i);
      drv_valid = 1'b1;
      drv_last  = (rr == 2);
      cycle();
    end
    for (int i = 0; i < N; i++) drv_data[i] = rowpat(32, i);
    drv_last = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cycle();
      check($sformatf("t4_hold%0d_ready", k), 64'(bus0.in_ready), 64'(k == 16));
    end
    cycle();
    check("t4_b_lane0_v", 64'(bus0.out_valid[0]), 64'(1));
    check("t4_b_lane0", 64'(bus0.out_data[0 +: OW]), 64'(29'h1FA0_2000));
    for (int i = 0; i < N; i++) drv_data[i] = rowpat(33, i);
    drv_last = 1'b1;
    cycle();
    drv_valid = 1'b0;
    repeat (17) cycle();

    // Reset while rows are in flight.
    drv_last = 1'b0;
    for (int rr = 0; rr < 4; rr++) begin
      for (int i = 0; i < N; i++) drv_data[i] = rowpat(rr + 48, i);
      drv_valid = 1'b1;
      cycle();
    end
    srstn = 1'b0;
    cycle();
    check("t5_out_valid", 64'(bus0.out_valid), 64'(0));
    check("t5_done", 64'(bus0.done), 64'(0));
    check("t5_busy", 64'(bus0.busy), 64'(0));
    check("t5_ready", 64'(bus0.in_ready), 64'(1));
    srstn     = 1'b1;
    drv_valid = 1'b0;
    repeat (20) cycle();

    // Signed lane ramp with random in_valid.
    r = 0;
    for (int g = 0; g < 300 && r < 12; g++) begin
      logic acc;
      for (int i = 0; i < N; i++) drv_data[i] = QW'(i*1000 - 8000 + r*37);
      drv_valid = 1'($urandom_range(0, 1));
      drv_last  = (r == 11);
      acc = drv_valid && (flush_left == 0);
      cycle();
      if (acc) r++;
    end
    check("t6_rows_accepted", 64'(r), 64'(12));
    drv_valid = 1'b0;
    repeat (18) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
